// File: rtl/kamacore_pipeline_register.sv
// kamacore_pipeline_register
// Valid/ready pipeline stage between two kamacore stages. With SKID=1 it is a
// two-entry skid buffer whose in_ready comes from a registered full flag, so
// there is no combinational path from out_ready to in_ready. With SKID=0 it
// is a single entry whose in_ready looks through to out_ready. hold freezes
// the stage, flush drops every held entry, and stall_count saturates.
module kamacore_pipeline_register #(
  parameter int CPU_WIDTH       = 32,
  parameter int REG_ADDR_WIDTH  = 5,
  parameter int SKID            = 1,
  parameter int STALL_CNT_WIDTH = 16
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      hold,
  input  logic                                      flush,
  input  logic                                      in_valid,
  output logic                                      in_ready,
  input  logic [5*CPU_WIDTH+REG_ADDR_WIDTH+5-1:0]   in_payload,
  output logic                                      out_valid,
  input  logic                                      out_ready,
  output logic [5*CPU_WIDTH+REG_ADDR_WIDTH+5-1:0]   out_payload,
  output logic [1:0]                                occupancy,
  output logic [STALL_CNT_WIDTH-1:0]                stall_count
);

  localparam int PW = 5*CPU_WIDTH + REG_ADDR_WIDTH + 5;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  logic                       w_in_ready;
  logic                       w_head_valid;
  logic [PW-1:0]              w_head_payload;
  logic [1:0]                 w_occupancy;
  logic                       w_in_xfer;
  logic                       w_out_xfer;
  logic [STALL_CNT_WIDTH-1:0] r_stall;

  // hold masks both handshakes; the head entry itself is kept untouched
  assign w_in_xfer   = in_valid && w_in_ready;
  assign w_out_xfer  = w_head_valid && !hold && out_ready;

  assign in_ready    = w_in_ready;
  assign out_valid   = w_head_valid && !hold;
  assign out_payload = w_head_payload;
  assign occupancy   = w_occupancy;
  assign stall_count = r_stall;

  generate
    if (SKID != 0) begin : g_skid
      state_t        r_state;
      logic          r_full;
      logic [PW-1:0] r_main;
      logic [PW-1:0] r_skid;

      // r_full is a plain flop so in_ready never depends on out_ready
      assign w_in_ready     = !r_full && !hold;
      assign w_head_valid   = (r_state != ST_EMPTY);
      assign w_head_payload = r_main;

      // Entry-count FSM; reset beats flush, flush beats any transfer
      always_ff @(posedge clk) begin
        if (rst) begin
          r_state <= ST_EMPTY;
          r_full  <= 1'b0;
        end else if (flush) begin
          r_state <= ST_EMPTY;
          r_full  <= 1'b0;
        end else begin
          case (r_state)
            ST_EMPTY: begin
              if (w_in_xfer) begin
                r_state <= ST_ONE;
              end
            end
            ST_ONE: begin
              if (w_in_xfer && !w_out_xfer) begin
                r_state <= ST_FULL;
                r_full  <= 1'b1;
              end else if (!w_in_xfer && w_out_xfer) begin
                r_state <= ST_EMPTY;
              end
            end
            ST_FULL: begin
              if (w_out_xfer) begin
                r_state <= ST_ONE;
                r_full  <= 1'b0;
              end
            end
            default: begin
              r_state <= ST_EMPTY;
              r_full  <= 1'b0;
            end
          endcase
        end
      end

      // Payload steering; writes during flush land in entries about to be invalid
      always_ff @(posedge clk) begin
        case (r_state)
          ST_EMPTY: begin
            if (w_in_xfer) begin
              r_main <= in_payload;
            end
          end
          ST_ONE: begin
            if (w_in_xfer && w_out_xfer) begin
              r_main <= in_payload;
            end else if (w_in_xfer) begin
              r_skid <= in_payload;
            end
          end
          ST_FULL: begin
            if (w_out_xfer) begin
              r_main <= r_skid;
            end
          end
          default: begin
            r_main <= r_main;
          end
        endcase
      end

      // Occupancy decoded from the registered state only
      always_comb begin
        w_occupancy = 2'd0;
        case (r_state)
          ST_EMPTY: w_occupancy = 2'd0;
          ST_ONE:   w_occupancy = 2'd1;
          ST_FULL:  w_occupancy = 2'd2;
          default:  w_occupancy = 2'd0;
        endcase
      end
    end else begin : g_single
      logic          r_valid;
      logic [PW-1:0] r_data;

      // Look-through ready: a departing entry frees the slot in the same cycle
      assign w_in_ready     = (!r_valid || out_ready) && !hold;
      assign w_head_valid   = r_valid;
      assign w_head_payload = r_data;
      assign w_occupancy    = {1'b0, r_valid};

      // Single valid bit; an arriving entry wins over a departing one
      always_ff @(posedge clk) begin
        if (rst) begin
          r_valid <= 1'b0;
        end else if (flush) begin
          r_valid <= 1'b0;
        end else if (w_in_xfer) begin
          r_valid <= 1'b1;
        end else if (w_out_xfer) begin
          r_valid <= 1'b0;
        end else begin
          r_valid <= r_valid;
        end
      end

      // Capture the payload on every accepted input
      always_ff @(posedge clk) begin
        if (w_in_xfer) begin
          r_data <= in_payload;
        end
      end
    end
  endgenerate

  // Saturating stall counter: head present but blocked by out_ready or hold
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall <= '0;
    end else if (w_head_valid && (!out_ready || hold) && (r_stall != {STALL_CNT_WIDTH{1'b1}})) begin
      r_stall <= r_stall + STALL_CNT_WIDTH'(1);
    end else begin
      r_stall <= r_stall;
    end
  end

endmodule

// File: tb/tb_kamacore_pipeline_register.sv
// Bench for kamacore_pipeline_register: three instances (default skid build,
// skid build with a 4-bit stall counter, single-entry build) share stimulus and
// are each compared every cycle against a small FIFO reference model.
module tb_kamacore_pipeline_register;

  localparam int CW = 32;
  localparam int RW = 5;
  localparam int PW = 5*CW + RW + 5;

  logic          clk;
  logic          rst;
  logic          hold;
  logic          flush;
  logic          in_valid;
  logic          out_ready;
  logic [PW-1:0] in_payload;

  logic          rdy0, rdy1, rdy2;
  logic          vld0, vld1, vld2;
  logic [PW-1:0] pl0, pl1, pl2;
  logic [1:0]    occ0, occ1, occ2;
  logic [15:0]   st0, st2;
  logic [3:0]    st1;

  logic          rdy_o [3];
  logic          vld_o [3];
  logic [PW-1:0] pl_o  [3];
  logic [1:0]    occ_o [3];
  logic [15:0]   st_o  [3];

  int total = 0;
  int bad   = 0;

  // reference model: per instance a FIFO of up to two entries and a stall count
  logic [PW-1:0] mq [3][2];
  int            mcnt   [3];
  int            mstall [3];
  int            mcap_skid [3];
  int            msmax  [3];

  kamacore_pipeline_register #(.CPU_WIDTH(CW), .REG_ADDR_WIDTH(RW), .SKID(1), .STALL_CNT_WIDTH(16)) u_dut (
    .clk(clk), .rst(rst), .hold(hold), .flush(flush), .in_valid(in_valid), .in_ready(rdy0),
    .in_payload(in_payload), .out_valid(vld0), .out_ready(out_ready), .out_payload(pl0),
    .occupancy(occ0), .stall_count(st0));

  kamacore_pipeline_register #(.CPU_WIDTH(CW), .REG_ADDR_WIDTH(RW), .SKID(1), .STALL_CNT_WIDTH(4)) u_sat (
    .clk(clk), .rst(rst), .hold(hold), .flush(flush), .in_valid(in_valid), .in_ready(rdy1),
    .in_payload(in_payload), .out_valid(vld1), .out_ready(out_ready), .out_payload(pl1),
    .occupancy(occ1), .stall_count(st1));

  kamacore_pipeline_register #(.CPU_WIDTH(CW), .REG_ADDR_WIDTH(RW), .SKID(0), .STALL_CNT_WIDTH(16)) u_s0 (
    .clk(clk), .rst(rst), .hold(hold), .flush(flush), .in_valid(in_valid), .in_ready(rdy2),
    .in_payload(in_payload), .out_valid(vld2), .out_ready(out_ready), .out_payload(pl2),
    .occupancy(occ2), .stall_count(st2));

  assign rdy_o[0] = rdy0;  assign rdy_o[1] = rdy1;  assign rdy_o[2] = rdy2;
  assign vld_o[0] = vld0;  assign vld_o[1] = vld1;  assign vld_o[2] = vld2;
  assign pl_o[0]  = pl0;   assign pl_o[1]  = pl1;   assign pl_o[2]  = pl2;
  assign occ_o[0] = occ0;  assign occ_o[1] = occ1;  assign occ_o[2] = occ2;
  assign st_o[0]  = st0;   assign st_o[1]  = {12'd0, st1}; assign st_o[2] = st2;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int k, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s[%0d] observed=%0h expected=%0h", tag, k, obs, exp);
    end
  endtask

  function automatic logic [PW-1:0] rnd_payload();
    logic [191:0] t;
    t = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    return t[PW-1:0];
  endfunction

  // compare every instance with the model, then advance the model by one clock
  task automatic tick();
    int  sz;
    bit  rdy, ov, ix, ox;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      sz  = mcnt[k];
      rdy = !hold && ((mcap_skid[k] != 0) ? (sz < 2) : (sz == 0 || out_ready));
      ov  = (sz > 0) && !hold;
      chk("in_ready",  k, PW'(rdy_o[k]), PW'(rdy));
      chk("out_valid", k, PW'(vld_o[k]), PW'(ov));
      chk("occupancy", k, PW'(occ_o[k]), PW'(sz));
      chk("stall",     k, PW'(st_o[k]),  PW'(mstall[k]));
      if (sz > 0) begin
        chk("payload", k, pl_o[k], mq[k][0]);
      end
      ix = in_valid && rdy;
      ox = ov && out_ready;
      if (sz > 0 && (!out_ready || hold) && mstall[k] < msmax[k]) mstall[k]++;
      if (rst) begin
        mcnt[k]   = 0;
        mstall[k] = 0;
      end else if (flush) begin
        mcnt[k] = 0;
      end else begin
        if (ox) begin
          mq[k][0] = mq[k][1];
          mcnt[k]--;
        end
        if (ix) begin
          mq[k][mcnt[k]] = in_payload;
          mcnt[k]++;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit r, input bit h, input bit f, input bit iv, input bit ordy, input logic [PW-1:0] p);
    rst = r; hold = h; flush = f; in_valid = iv; out_ready = ordy; in_payload = p;
  endtask

  initial begin
    mcap_skid[0] = 1; mcap_skid[1] = 1; mcap_skid[2] = 0;
    msmax[0] = 65535; msmax[1] = 15; msmax[2] = 65535;
    for (int k = 0; k < 3; k++) begin
      mcnt[k] = 0;
      mstall[k] = 0;
    end
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    @(posedge clk);
    #1;

    // reset state, including hold/flush ignored during reset
    tick();
    drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, rnd_payload());
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, '0);
    tick();

    // streaming payloads 0..9 with out_ready held high
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, PW'(i));
      tick();
    end
    for (int k = 0; k < 3; k++) chk("stream_occ", k, PW'(occ_o[k]), PW'(1));
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, '0);
    tick();
    tick();

    // backpressure: A and B pushed while the sink is blocked
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, rnd_payload());
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, rnd_payload());
    tick();
    chk("bp_occ2", 0, PW'(occ_o[0]), PW'(2));
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, rnd_payload());
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, '0);
      tick();
    end

    // hold for three cycles with a single entry and out_ready high
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, '0);
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, rnd_payload());
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, rnd_payload());
      tick();
    end
    chk("hold_stall3", 0, PW'(st_o[0]), PW'(3));
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, '0);
    tick();
    tick();

    // flush with a simultaneous push while full
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, rnd_payload());
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, rnd_payload());
    tick();
    drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, rnd_payload());
    tick();
    chk("flush_occ0", 0, PW'(occ_o[0]), PW'(0));
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, '0);
    tick();
    tick();

    // saturation of the 4-bit counter over 20 blocked cycles
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, rnd_payload());
    tick();
    for (int i = 0; i < 20; i++) begin
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
      tick();
    end
    chk("sat15", 1, PW'(st_o[1]), PW'(15));

    // reset while full with a non-zero stall count
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, rnd_payload());
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, rnd_payload());
    tick();
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
      tick();
    end
    chk("mid_stall5", 0, PW'(st_o[0]), PW'(5));
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, rnd_payload());
    tick();
    chk("mid_rst_occ", 0, PW'(occ_o[0]), PW'(0));
    chk("mid_rst_st",  0, PW'(st_o[0]),  PW'(0));
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, '0);
    tick();

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(99) < 2), ($urandom_range(99) < 10), ($urandom_range(99) < 4),
            ($urandom_range(99) < 70), ($urandom_range(99) < 60), rnd_payload());
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/kamacore_pipeline_register.md
KAMACORE_PIPELINE_REGISTER -- requirements
Module: kamacore_pipeline_register

Interface
REQ-001 Parameter CPU_WIDTH, default 32, width of data fields (instruction, alu_result, rs1_data, rs2_data, data_memory_result).
REQ-002 Parameter REG_ADDR_WIDTH, default 5, width of destination_register.
REQ-003 Parameter SKID, default 1; 1 = two-entry skid buffer with registered in_ready, 0 = single entry with combinational in_ready.
REQ-004 Parameter STALL_CNT_WIDTH, default 16, width of stall_count.
REQ-005 Single clock, clk; reset rst is synchronous and active-high.
REQ-006 clk  input  1  rising-edge clock.
REQ-007 rst  input  1  synchronous active-high reset.
REQ-008 hold  input  1  freeze stage: no accept, no emit.
REQ-009 flush  input  1  discard all held entries.
REQ-010 in_valid / in_ready  input / output  1 / 1  upstream handshake.
REQ-011 in_payload  input  5*CPU_WIDTH+REG_ADDR_WIDTH+5  packed {instruction, destination_register, alu_result, rs1_data, rs2_data, data_memory_result, control_memory_read, control_memory_write, control_write_rd, control_write_register, control_alu_use_immediate}.
REQ-012 out_valid / out_ready  output / input  1 / 1  downstream handshake.
REQ-013 out_payload  output  same as in_payload  head-entry contents, same packing.
REQ-014 occupancy  output  2  number of valid entries (0..2; max 1 when SKID=0).
REQ-015 stall_count  output  STALL_CNT_WIDTH  saturating count of stalled cycles.

Function
REQ-016 Transfer in: in_valid && in_ready; transfer out: out_valid && out_ready; payload moves only on a transfer.
REQ-017 hold=1: in_ready=0, out_valid=0 combinationally; entries and payload unchanged.
REQ-018 flush=1: both entries invalidated at next edge; priority over hold and any transfer in the same cycle; in-flight input that cycle dropped.
REQ-019 SKID=1, states EMPTY (0 entries), ONE (main valid), FULL (main+skid valid).
REQ-020 SKID=1 in_ready = (state != FULL) && !hold, driven from a registered full flag (no path from out_ready to in_ready).
REQ-021 EMPTY: in transfer -> ONE, payload into main.
REQ-022 ONE: in only -> FULL (payload into skid); out only -> EMPTY; in+out -> ONE with main <= in_payload.
REQ-023 FULL: out transfer -> ONE with main <= skid; no in transfer possible.
REQ-024 SKID=0: in_ready = (!valid || out_ready) && !hold; in+out same cycle replaces entry; one-cycle latency, full throughput.
REQ-025 Latency in_valid to out_valid: exactly 1 cycle when empty and no hold; order strictly FIFO.
REQ-026 out_payload stable while out_valid=1 and out_ready=0; payload of invalid entries don't-care but no X propagation to occupancy/valid.
REQ-027 stall_count increments by 1 each cycle out_valid_internal=1 && (out_ready=0 || hold=1); saturates at all-ones; unaffected by flush.
REQ-028 occupancy reflects registered state, updates one cycle after transfer.

Reset
REQ-029 rst=1 at edge: state EMPTY, occupancy=0, out_valid=0, stall_count=0, in_ready=1 from next cycle (if hold=0).
REQ-030 rst has priority over flush, hold and transfers; entries mid-stall are discarded.
REQ-031 Payload registers need no reset; out_payload after reset is don't-care until first transfer.

Verification
REQ-032 Streaming: in_valid=1 for 10 cycles, out_ready=1 -> payloads 0..9 emerge in order, one per cycle, 1-cycle latency, occupancy=1 steady.
REQ-033 Backpressure (SKID=1): out_ready=0, push A,B -> occupancy=2, in_ready=0 cycle after B; out_ready=1 -> A then B emitted, in_ready=1 after A leaves.
REQ-034 Hold: entry A valid, hold=1 for 3 cycles with out_ready=1 -> out_valid=0, in_ready=0, A retained, stall_count=3; release -> A emitted.
REQ-035 Flush with simultaneous push: FULL, flush=1 and in_valid=1 -> next cycle occupancy=0, out_valid=0, pushed payload never emitted.
REQ-036 Saturation: STALL_CNT_WIDTH=4, 20 stalled cycles -> stall_count=15 and holds.
REQ-037 Reset mid-operation: FULL with stall_count=5, rst=1 one cycle -> occupancy=0, stall_count=0, out_valid=0; SKID=0 build repeats REQ-032 with no bubbles.
